// File: rtl/phyq_tx_arb_pkg.sv
// Shared types and constants for the tx PHY queue arbiter.
// Holds the FSM encoding and the 9-bit queue word layout.
// No logic here; imported by the arbiter and its sub-module.
package phyq_tx_arb_pkg;

  // Arbiter states: wait for a request, skip filler, move a frame,
  // discard the tail of an over-long frame, then pad with gap words.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_HUNT  = 3'd1,
    ST_XFER  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_GAP   = 3'd4
  } state_e;

  // Queue word: bit 8 marks a frame byte, bits 7:0 carry the byte.
  localparam int          WORD_W          = 9;
  localparam int          FRAME_VALID_BIT = 8;
  localparam logic [8:0]  GAP_WORD        = 9'h000;

  // Width of the frame length counter (MAX_LEN tops out at 2047).
  localparam int          LEN_W           = 11;
  // Width of the owed gap-word counter (GAP tops out at 15).
  localparam int          GAP_W           = 4;

  // One-hot grant vector for a port index.
  function automatic logic [1:0] port_onehot(input logic port);
    return port ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/phyq_rr_pick.sv
// Two-requester round-robin selector producing a one-hot grant.
// Purely combinational, zero latency.
// No backpressure; grant is 00 when nothing requests.
module phyq_rr_pick
  import phyq_tx_arb_pkg::*;
(
  input  logic [1:0] req_i,
  input  logic       rr_i,
  output logic [1:0] grant_o
);

  // A lone requester always wins; on a tie the rr port wins.
  always_comb begin
    grant_o = 2'b00;
    case (req_i)
      2'b01:   grant_o = 2'b01;
      2'b10:   grant_o = 2'b10;
      2'b11:   grant_o = port_onehot(rr_i);
      default: grant_o = 2'b00;
    endcase
  end

endmodule

// File: rtl/phyq_tx_arb.sv
// Frame-level round-robin arbiter from two FWFT producer queues into the tx PHY queue.
// 2 cycles of arbitration (IDLE, HUNT) before the first byte, then 1 word per cycle.
// Stalls on phy_full or an empty source; pops and writes are combinational from state.
module phyq_tx_arb
  import phyq_tx_arb_pkg::*;
#(
  parameter int GAP     = 8,
  parameter int MAX_LEN = 1536
) (
  input  logic        pcie_clk,
  input  logic        sys_rst_n,
  input  logic [8:0]  s0_dout,
  input  logic        s0_empty,
  output logic        s0_rd_en,
  input  logic [8:0]  s1_dout,
  input  logic        s1_empty,
  output logic        s1_rd_en,
  output logic [8:0]  phy_din,
  input  logic        phy_full,
  output logic        phy_wr_en,
  output logic [1:0]  grant,
  output logic [15:0] frm_cnt0,
  output logic [15:0] frm_cnt1,
  output logic [7:0]  trunc_cnt
);

  state_e             state_q, state_d;
  logic [1:0]         grant_q, grant_d;
  logic               rr_q, rr_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [GAP_W-1:0]   gap_q, gap_d;
  logic [15:0]        frm0_q, frm0_d;
  logic [15:0]        frm1_q, frm1_d;
  logic [7:0]         trunc_q, trunc_d;

  logic [1:0]         req;
  logic [1:0]         pick;
  logic               sel;
  logic [WORD_W-1:0]  src_dout;
  logic               src_empty;
  logic               pop;
  logic               wr;
  logic [WORD_W-1:0]  din;
  logic               frm_inc;

  assign req       = {~s1_empty, ~s0_empty};
  // The owning port index; only meaningful while grant_q is non-zero.
  assign sel       = grant_q[1];
  assign src_dout  = sel ? s1_dout : s0_dout;
  assign src_empty = sel ? s1_empty : s0_empty;

  phyq_rr_pick u_pick (
    .req_i   (req),
    .rr_i    (rr_q),
    .grant_o (pick)
  );

  // Next-state, pop/write strobes and counter updates for the frame mover.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    rr_d    = rr_q;
    len_d   = len_q;
    gap_d   = gap_q;
    frm0_d  = frm0_q;
    frm1_d  = frm1_q;
    trunc_d = trunc_q;
    pop     = 1'b0;
    wr      = 1'b0;
    din     = GAP_WORD;
    frm_inc = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (|req) begin
          grant_d = pick;
          state_d = ST_HUNT;
        end
      end

      // Skip filler ahead of the frame; an empty source forfeits the grant.
      ST_HUNT: begin
        if (src_empty) begin
          state_d = ST_IDLE;
          grant_d = 2'b00;
          rr_d    = ~sel;
        end else if (!src_dout[FRAME_VALID_BIT]) begin
          pop = 1'b1;
        end else begin
          state_d = ST_XFER;
          len_d   = '0;
        end
      end

      ST_XFER: begin
        if (!src_empty && !phy_full) begin
          pop = 1'b1;
          wr  = 1'b1;
          din = src_dout;
          if (src_dout[FRAME_VALID_BIT]) begin
            len_d = len_q + 1'b1;
            if (len_q == LEN_W'(MAX_LEN - 1)) begin
              // Over-long frame: cut it here and throw the rest away.
              frm_inc = 1'b1;
              trunc_d = (trunc_q == 8'hFF) ? trunc_q : trunc_q + 1'b1;
              state_d = ST_DRAIN;
            end
          end else begin
            // The delimiter itself goes out as the first gap word.
            frm_inc = 1'b1;
            if (GAP == 1) begin
              state_d = ST_IDLE;
              grant_d = 2'b00;
              rr_d    = ~sel;
            end else begin
              state_d = ST_GAP;
              gap_d   = GAP_W'(GAP - 1);
            end
          end
        end
      end

      // Discard the truncated tail; the PHY side is untouched so phy_full is irrelevant.
      ST_DRAIN: begin
        if (!src_empty) begin
          pop = 1'b1;
          if (!src_dout[FRAME_VALID_BIT]) begin
            state_d = ST_GAP;
            gap_d   = GAP_W'(GAP);
          end
        end
      end

      ST_GAP: begin
        if (!phy_full) begin
          wr    = 1'b1;
          din   = GAP_WORD;
          gap_d = gap_q - 1'b1;
          if (gap_q == GAP_W'(1)) begin
            state_d = ST_IDLE;
            grant_d = 2'b00;
            rr_d    = ~sel;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
        grant_d = 2'b00;
      end
    endcase

    if (frm_inc) begin
      if (sel) frm1_d = frm1_q + 1'b1;
      else     frm0_d = frm0_q + 1'b1;
    end
  end

  // State and counter registers with synchronous active-low reset.
  always_ff @(posedge pcie_clk) begin
    if (!sys_rst_n) begin
      state_q <= ST_IDLE;
      grant_q <= 2'b00;
      rr_q    <= 1'b0;
      len_q   <= '0;
      gap_q   <= '0;
      frm0_q  <= '0;
      frm1_q  <= '0;
      trunc_q <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      rr_q    <= rr_d;
      len_q   <= len_d;
      gap_q   <= gap_d;
      frm0_q  <= frm0_d;
      frm1_q  <= frm1_d;
      trunc_q <= trunc_d;
    end
  end

  // Strobes are held off during reset so a reset cycle never moves a word.
  assign s0_rd_en  = pop & grant_q[0] & sys_rst_n;
  assign s1_rd_en  = pop & grant_q[1] & sys_rst_n;
  assign phy_wr_en = wr & sys_rst_n;
  assign phy_din   = phy_wr_en ? din : GAP_WORD;

  assign grant     = grant_q;
  assign frm_cnt0  = frm0_q;
  assign frm_cnt1  = frm1_q;
  assign trunc_cnt = trunc_q;

endmodule

// File: tb/tb_phyq_tx_arb.sv
// Bench for phyq_tx_arb: table rows, directed corner sequences and a randomized run.
// Sources are modelled as FWFT queues, the PHY queue as a capture list.
// Expected PHY stream is built per frame from the framing rules, merged round-robin.
module tb_phyq_tx_arb;

  localparam int GAP     = 8;
  localparam int MAX_LEN = 1536;

  logic        pcie_clk = 1'b0;
  logic        sys_rst_n = 1'b0;
  logic [8:0]  s0_dout = 9'h000, s1_dout = 9'h000;
  logic        s0_empty = 1'b1, s1_empty = 1'b1;
  logic        s0_rd_en, s1_rd_en;
  logic [8:0]  phy_din;
  logic        phy_full = 1'b0;
  logic        phy_wr_en;
  logic [1:0]  grant;
  logic [15:0] frm_cnt0, frm_cnt1;
  logic [7:0]  trunc_cnt;

  phyq_tx_arb #(.GAP(GAP), .MAX_LEN(MAX_LEN)) dut (
    .pcie_clk  (pcie_clk),
    .sys_rst_n (sys_rst_n),
    .s0_dout   (s0_dout),
    .s0_empty  (s0_empty),
    .s0_rd_en  (s0_rd_en),
    .s1_dout   (s1_dout),
    .s1_empty  (s1_empty),
    .s1_rd_en  (s1_rd_en),
    .phy_din   (phy_din),
    .phy_full  (phy_full),
    .phy_wr_en (phy_wr_en),
    .grant     (grant),
    .frm_cnt0  (frm_cnt0),
    .frm_cnt1  (frm_cnt1),
    .trunc_cnt (trunc_cnt)
  );

  always #5 pcie_clk = ~pcie_clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  int vectors = 0;
  int miscompares = 0;

  // Source queues, per-port expected words and per-frame word counts, PHY capture.
  logic [8:0] q0[$], q1[$], exp0[$], exp1[$], exp_all[$], out_q[$];
  int         fl0[$], fl1[$];
  int         m_rr, m_f0, m_f1, m_tr;
  int         full_pct = 0;
  bit         force_full = 1'b0;
  int         viol = 0;
  string      viol_msg = "";
  logic       r0, r1, w;
  logic [8:0] d;

  typedef struct {
    int len0; int fill0; int len1; int fill1; int full_pct;
    int exp_words; int exp_f0; int exp_f1; int exp_tr;
  } row_t;
  row_t tbl[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp,
                     input string note = "");
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d %s", name, act, exp, note);
    end
  endtask

  // One clock: drive inputs, sample combinational strobes, then apply the edge.
  task automatic tick();
    s0_dout  = (q0.size() != 0) ? q0[0] : 9'h000;
    s0_empty = (q0.size() == 0);
    s1_dout  = (q1.size() != 0) ? q1[0] : 9'h000;
    s1_empty = (q1.size() == 0);
    phy_full = force_full || ($urandom_range(99) < full_pct);
    #1;
    r0 = s0_rd_en; r1 = s1_rd_en; w = phy_wr_en; d = phy_din;
    if ((r0 && s0_empty) || (r1 && s1_empty) || (r0 && r1) ||
        (w && phy_full) || (!w && d != 9'h000)) begin
      if (viol == 0)
        viol_msg = $sformatf("t=%0t rd=%b%b wr=%b din=%h full=%b empty=%b%b",
                             $time, r1, r0, w, d, phy_full, s1_empty, s0_empty);
      viol++;
    end
    @(posedge pcie_clk);
    if (r0 && q0.size() != 0) void'(q0.pop_front());
    if (r1 && q1.size() != 0) void'(q1.pop_front());
    if (w) out_q.push_back(d);
    #1;
  endtask

  task automatic push_word(input int p, input logic [8:0] wd, input bit to_exp);
    if (to_exp) begin
      if (p == 0) exp0.push_back(wd); else exp1.push_back(wd);
    end else begin
      if (p == 0) q0.push_back(wd); else q1.push_back(wd);
    end
  endtask

  // Source: fillers, len frame bytes, delimiter. PHY: bytes up to MAX_LEN, then GAP words.
  task automatic build_frame(input int p, input int len, input int fill, input logic [7:0] dbyte);
    logic [8:0] wd;
    int n = 0;
    for (int i = 0; i < fill; i++) push_word(p, {1'b0, 8'($urandom_range(255))}, 1'b0);
    for (int i = 0; i < len; i++) begin
      wd = {1'b1, 8'($urandom_range(255))};
      push_word(p, wd, 1'b0);
      if (i < MAX_LEN) begin push_word(p, wd, 1'b1); n++; end
    end
    push_word(p, {1'b0, dbyte}, 1'b0);
    if (len < MAX_LEN) begin
      push_word(p, {1'b0, dbyte}, 1'b1);
      for (int i = 1; i < GAP; i++) push_word(p, 9'h000, 1'b1);
    end else begin
      for (int i = 0; i < GAP; i++) push_word(p, 9'h000, 1'b1);
      if (m_tr < 255) m_tr++;
    end
    n += GAP;
    if (p == 0) begin fl0.push_back(n); m_f0++; end
    else        begin fl1.push_back(n); m_f1++; end
  endtask

  // Merge whole frames: rr port first when it has one, then the pointer flips.
  task automatic build_expected();
    int n;
    while (fl0.size() != 0 || fl1.size() != 0) begin
      if ((m_rr == 0 && fl0.size() == 0) || (m_rr == 1 && fl1.size() == 0)) m_rr ^= 1;
      if (m_rr == 0) begin n = fl0.pop_front(); repeat (n) exp_all.push_back(exp0.pop_front()); end
      else           begin n = fl1.pop_front(); repeat (n) exp_all.push_back(exp1.pop_front()); end
      m_rr ^= 1;
    end
  endtask

  task automatic compare_stream(input string name);
    int mism = 0;
    int first = -1;
    int n;
    build_expected();
    chk({name, " word count"}, out_q.size(), exp_all.size());
    n = (out_q.size() < exp_all.size()) ? out_q.size() : exp_all.size();
    for (int i = 0; i < n; i++)
      if (out_q[i] !== exp_all[i]) begin
        if (first < 0) first = i;
        mism++;
      end
    chk({name, " word mismatches"}, mism, 0,
        (first < 0) ? "" : $sformatf("(first at %0d: got %h, expected %h)",
                                     first, out_q[first], exp_all[first]));
    out_q.delete();
    exp_all.delete();
  endtask

  // Run until both sources are empty and the grant has dropped, bounded by max cycles.
  task automatic run_idle(input string name, input int max);
    int idle = 0;
    int n = 0;
    while (idle < 2 && n < max) begin
      tick();
      n++;
      if (q0.size() == 0 && q1.size() == 0 && grant == 2'b00) idle++;
      else idle = 0;
    end
    chk({name, " completed within budget"}, (idle >= 2), 1);
    chk({name, " protocol violations"}, viol, 0, viol_msg);
    viol = 0;
  endtask

  task automatic do_reset();
    q0.delete(); q1.delete(); exp0.delete(); exp1.delete();
    fl0.delete(); fl1.delete(); out_q.delete(); exp_all.delete();
    sys_rst_n = 1'b0;
    tick();
    sys_rst_n = 1'b1;
    m_rr = 0; m_f0 = 0; m_f1 = 0; m_tr = 0; viol = 0;
  endtask

  task automatic chk_counters(input string name);
    chk({name, " frm_cnt0"}, frm_cnt0, m_f0);
    chk({name, " frm_cnt1"}, frm_cnt1, m_f1);
    chk({name, " trunc_cnt"}, trunc_cnt, m_tr);
    chk({name, " grant idle"}, grant, 2'b00);
  endtask

  initial begin
    logic [8:0] first_w;
    int nw;
    int cnt;

    //        len0  fill0 len1  fill1 full  words f0 f1 tr
    tbl[0] = '{60,   0,    0,    0,    0,    68,   1, 0, 0};
    tbl[1] = '{20,   0,    25,   0,    0,    61,   1, 1, 0};
    tbl[2] = '{0,    0,    1600, 0,    0,    1544, 0, 1, 1};
    tbl[3] = '{10,   3,    0,    0,    0,    18,   1, 0, 0};
    tbl[4] = '{1536, 0,    0,    0,    0,    1544, 1, 0, 1};
    tbl[5] = '{1535, 0,    0,    0,    0,    1543, 1, 0, 0};
    tbl[6] = '{30,   1,    30,   2,    40,   76,   1, 1, 0};
    tbl[7] = '{1,    0,    1,    0,    0,    18,   1, 1, 0};

    // Reset values, arbitration latency and back-to-back throughput.
    do_reset();
    chk("reset grant", grant, 2'b00);
    chk("reset frm_cnt0", frm_cnt0, 0);
    chk("reset frm_cnt1", frm_cnt1, 0);
    chk("reset trunc_cnt", trunc_cnt, 0);
    build_frame(0, 60, 0, 8'h00);
    first_w = q0[0];
    tick();
    chk("idle cycle no pop/write", {r0, r1, w}, 3'b000);
    chk("grant visible after idle", grant, 2'b01);
    tick();
    chk("hunt cycle no pop/write", {r0, w}, 2'b00);
    tick();
    chk("first word on third cycle", {w, d}, {1'b1, first_w});
    nw = 0;
    repeat (59) begin tick(); nw += int'(w); end
    chk("back-to-back writes", nw, 59);
    run_idle("latency", 200);
    compare_stream("latency");
    chk_counters("latency");

    // Table rows: each starts from reset with both sources loaded together.
    for (int i = 0; i < 8; i++) begin
      string nm;
      nm = $sformatf("row%0d", i);
      full_pct = tbl[i].full_pct;
      do_reset();
      if (tbl[i].len0 > 0) build_frame(0, tbl[i].len0, tbl[i].fill0, 8'h00);
      if (tbl[i].len1 > 0) build_frame(1, tbl[i].len1, tbl[i].fill1, 8'h00);
      run_idle(nm, 20000);
      chk({nm, " phy words"}, out_q.size(), tbl[i].exp_words);
      compare_stream(nm);
      chk({nm, " frm_cnt0"}, frm_cnt0, tbl[i].exp_f0);
      chk({nm, " frm_cnt1"}, frm_cnt1, tbl[i].exp_f1);
      chk({nm, " trunc_cnt"}, trunc_cnt, tbl[i].exp_tr);
    end
    full_pct = 0;

    // phy_full held for 5 cycles mid-frame: nothing pops, nothing is written.
    do_reset();
    build_frame(0, 40, 0, 8'h00);
    cnt = 0;
    while (out_q.size() < 15 && cnt < 100) begin tick(); cnt++; end
    chk("stall reached mid-frame", (out_q.size() >= 15), 1);
    force_full = 1'b1;
    repeat (5) begin
      tick();
      chk("stall no pop/write", {r0, w}, 2'b00);
    end
    force_full = 1'b0;
    run_idle("stall", 200);
    compare_stream("stall");
    chk_counters("stall");

    // Round-robin: after port 0 is served alone, a simultaneous pair goes to port 1 first.
    do_reset();
    build_frame(0, 5, 0, 8'h00);
    run_idle("rr solo", 100);
    compare_stream("rr solo");
    build_frame(0, 6, 0, 8'h00);
    build_frame(1, 6, 0, 8'h00);
    first_w = exp1[0];
    run_idle("rr pair", 200);
    chk("rr port1 served first", (out_q.size() != 0) ? out_q[0] : 9'h1FF, first_w);
    compare_stream("rr pair");
    chk_counters("rr");

    // Reset while XFER sits on the delimiter: the remnant is discarded by HUNT.
    do_reset();
    for (int i = 0; i < 12; i++) q0.push_back({1'b1, 8'(i + 8'h40)});
    q0.push_back(9'h000);
    cnt = 0;
    while (out_q.size() < 12 && cnt < 50) begin tick(); cnt++; end
    chk("reached mid-xfer", out_q.size(), 12);
    sys_rst_n = 1'b0;
    tick();
    chk("reset cycle no pop/write", {r0, r1, w}, 3'b000);
    sys_rst_n = 1'b1;
    out_q.delete();
    m_rr = 0; m_f0 = 0; m_f1 = 0; m_tr = 0;
    chk("mid reset grant", grant, 2'b00);
    chk("mid reset frm_cnt0", frm_cnt0, 0);
    build_frame(0, 8, 2, 8'h00);
    tick();
    chk("after reset idle no pop/write", {r0, r1, w}, 3'b000);
    run_idle("mid reset", 200);
    compare_stream("mid reset");
    chk_counters("mid reset");

    // Randomized frames on both ports with random backpressure.
    do_reset();
    full_pct = 25;
    for (int i = 0; i < 30; i++) begin
      int len;
      len = ($urandom_range(7) == 0) ? 1530 + int'($urandom_range(15))
                                     : 1 + int'($urandom_range(39));
      build_frame(int'($urandom_range(1)), len, int'($urandom_range(3)),
                  8'($urandom_range(255)));
    end
    run_idle("random", 40000);
    compare_stream("random");
    chk_counters("random");
    full_pct = 0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
